// File: rtl/tone_capture_pkg.sv
// Shared constants, note ordering and helpers for the tone capture block.
// Note index order A=0, C=1, D=2, F=3 matches the speaker players and the hex note display.
package tone_capture_pkg;

  localparam int unsigned PW          = 17;
  localparam int unsigned P_A_DEF     = 56818;
  localparam int unsigned P_C_DEF     = 47801;
  localparam int unsigned P_D_DEF     = 43592;
  localparam int unsigned P_F_DEF     = 35816;
  localparam int unsigned TOL_DEF     = 1000;
  localparam int unsigned TIMEOUT_DEF = 100000;

  typedef enum logic [1:0] {
    NOTE_A = 2'd0,
    NOTE_C = 2'd1,
    NOTE_D = 2'd2,
    NOTE_F = 2'd3
  } note_idx_e;

  typedef enum logic {
    IDLE = 1'b0,
    REC  = 1'b1
  } cap_state_e;

  function automatic logic in_window(input logic [PW-1:0] p, input logic [PW-1:0] ctr,
                                     input logic [PW-1:0] tol);
    return (p >= ctr - tol) && (p <= ctr + tol);
  endfunction

endpackage

// File: rtl/tone_capture_period_meter.sv
// Synchronizes the tone pin, measures rising-edge to rising-edge period and classifies it.
// Outputs a one-hot live note and the last (saturated) period.
module tone_period_meter
  import tone_capture_pkg::*;
#(
  parameter int unsigned P_A     = P_A_DEF,
  parameter int unsigned P_C     = P_C_DEF,
  parameter int unsigned P_D     = P_D_DEF,
  parameter int unsigned P_F     = P_F_DEF,
  parameter int unsigned TOL     = TOL_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic          clk,
  input  logic          resetN,
  input  logic          tone_in,
  output logic [3:0]    note_now,
  output logic [PW-1:0] period_out
);

  localparam logic [PW-1:0] PA = PW'(P_A);
  localparam logic [PW-1:0] PC = PW'(P_C);
  localparam logic [PW-1:0] PD = PW'(P_D);
  localparam logic [PW-1:0] PF = PW'(P_F);
  localparam logic [PW-1:0] TL = PW'(TOL);
  localparam logic [PW-1:0] TO = PW'(TIMEOUT);

  logic          tone_p0, tone_p1, tone_p2, edge_p3;
  logic [PW-1:0] pcount;
  logic          silent, cls_pend;

  function automatic logic [3:0] classify(input logic [PW-1:0] p);
    classify = '0;
    if (in_window(p, PA, TL))      classify[NOTE_A] = 1'b1;
    else if (in_window(p, PC, TL)) classify[NOTE_C] = 1'b1;
    else if (in_window(p, PD, TL)) classify[NOTE_D] = 1'b1;
    else if (in_window(p, PF, TL)) classify[NOTE_F] = 1'b1;
  endfunction

  function automatic logic [PW-1:0] sat_period(input logic [PW-1:0] c);
    return (c >= TO) ? TO : c + 1'b1;
  endfunction

  // p0/p1: synchronizer, p2: delayed copy, p3: registered rising-edge pulse
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      tone_p0 <= 1'b0;
      tone_p1 <= 1'b0;
      tone_p2 <= 1'b0;
      edge_p3 <= 1'b0;
    end else begin
      tone_p0 <= tone_in;
      tone_p1 <= tone_p0;
      tone_p2 <= tone_p1;
      edge_p3 <= tone_p1 & ~tone_p2;
    end
  end

  // Silent starts set after reset: with no previous edge the first one only restarts the count.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      pcount     <= '0;
      period_out <= '0;
      note_now   <= '0;
      silent     <= 1'b1;
      cls_pend   <= 1'b0;
    end else begin
      cls_pend <= 1'b0;
      if (edge_p3) begin
        pcount <= '0;
        silent <= 1'b0;
        if (!silent) begin
          period_out <= sat_period(pcount);
          cls_pend   <= 1'b1;
        end
      end else if (pcount >= TO) begin
        period_out <= TO;
        note_now   <= '0;
        silent     <= 1'b1;
      end else begin
        pcount <= pcount + 1'b1;
      end
      if (cls_pend) note_now <= classify(period_out);
    end
  end

endmodule

// File: rtl/tone_capture.sv
// Records which notes sounded during each beat step into four 16-step patterns.
// The meter classifies the live tone; this level owns the IDLE/REC FSM, sticky bits and patterns.
module tone_capture
  import tone_capture_pkg::*;
#(
  parameter int unsigned P_A     = P_A_DEF,
  parameter int unsigned P_C     = P_C_DEF,
  parameter int unsigned P_D     = P_D_DEF,
  parameter int unsigned P_F     = P_F_DEF,
  parameter int unsigned TOL     = TOL_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic          clk,
  input  logic          resetN,
  input  logic          capture_en,
  input  logic          beat_tick,
  input  logic          tone_in,
  output logic [15:0]   qOut1,
  output logic [15:0]   qOut2,
  output logic [15:0]   qOut3,
  output logic [15:0]   qOut4,
  output logic [3:0]    step,
  output logic [3:0]    note_now,
  output logic [PW-1:0] period_out,
  output logic          frame_done
);

  cap_state_e       state, state_nxt;
  logic             cap_d;
  logic [3:0]       sticky;
  logic [3:0][15:0] pat;
  logic             start, leave, write;

  tone_period_meter #(
    .P_A(P_A), .P_C(P_C), .P_D(P_D), .P_F(P_F), .TOL(TOL), .TIMEOUT(TIMEOUT)
  ) u_meter (
    .clk       (clk),
    .resetN    (resetN),
    .tone_in   (tone_in),
    .note_now  (note_now),
    .period_out(period_out)
  );

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    leave     = 1'b0;
    write     = 1'b0;
    case (state)
      IDLE: if (capture_en && !cap_d) begin
        state_nxt = REC;
        start     = 1'b1;
      end
      REC: if (!capture_en) begin
        state_nxt = IDLE;
        leave     = 1'b1;
      end else if (beat_tick) begin
        write = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // cap_d resets high so a level already high at reset release is not taken as a new start.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      cap_d      <= 1'b1;
      sticky     <= '0;
      step       <= '0;
      pat        <= '0;
      frame_done <= 1'b0;
    end else begin
      cap_d      <= capture_en;
      frame_done <= write && (step == 4'd15);
      if (start) begin
        pat    <= '0;
        step   <= '0;
        sticky <= '0;
      end else if (leave) begin
        step   <= '0;
        sticky <= '0;
      end else if (write) begin
        for (int k = 0; k < 4; k++) pat[k][step] <= sticky[k] | note_now[k];
        sticky <= '0;
        step   <= step + 1'b1;
      end else if (state == REC) begin
        sticky <= sticky | note_now;
      end
    end
  end

  assign qOut1 = pat[NOTE_A];
  assign qOut2 = pat[NOTE_C];
  assign qOut3 = pat[NOTE_D];
  assign qOut4 = pat[NOTE_F];

endmodule

// File: tb/tb_tone_capture.sv
// Bench for tone_capture with note periods scaled down so every scenario fits a short run.
module tb_tone_capture;

  localparam int TA = 284, TC = 239, TD = 218, TF = 179, TTOL = 5, TTO = 500;
  localparam int STEP_LEN = 800;

  logic        clk = 1'b0, resetN = 1'b0, capture_en = 1'b0, beat_tick = 1'b0, tone_in = 1'b0;
  logic [15:0] qOut1, qOut2, qOut3, qOut4;
  logic [3:0]  step, note_now;
  logic [16:0] period_out;
  logic        frame_done;

  int vectors = 0, miscompares = 0;
  int next_period = 0, alt_period = 0;
  int fd_cnt = 0;

  always #5 clk = ~clk;

  tone_capture #(
    .P_A(TA), .P_C(TC), .P_D(TD), .P_F(TF), .TOL(TTOL), .TIMEOUT(TTO)
  ) dut (
    .clk(clk), .resetN(resetN), .capture_en(capture_en), .beat_tick(beat_tick),
    .tone_in(tone_in), .qOut1(qOut1), .qOut2(qOut2), .qOut3(qOut3), .qOut4(qOut4),
    .step(step), .note_now(note_now), .period_out(period_out), .frame_done(frame_done)
  );

  always @(negedge clk) if (frame_done) fd_cnt++;

  // Square-wave source; a new period takes effect only at a rising edge.
  initial begin : tone_gen
    int cur;
    bit flip;
    flip = 1'b0;
    forever begin
      if (alt_period != 0 && flip) cur = alt_period;
      else cur = next_period;
      if (cur == 0) begin
        tone_in = 1'b0;
        @(negedge clk);
      end else begin
        flip = ~flip;
        tone_in = 1'b1;
        repeat (cur / 2) @(negedge clk);
        tone_in = 1'b0;
        repeat (cur - cur / 2) @(negedge clk);
      end
    end
  end

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  function automatic int center(input int k);
    case (k)
      0: return TA;
      1: return TC;
      2: return TD;
      default: return TF;
    endcase
  endfunction

  // Reference classification: first note whose window contains the period, A,C,D,F order.
  function automatic logic [3:0] ref_note(input int p);
    for (int k = 0; k < 4; k++)
      if (p >= center(k) - TTOL && p <= center(k) + TTOL) return 4'(1 << k);
    return 4'b0000;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic tick();
    @(posedge clk); #1 beat_tick = 1'b1;
    @(posedge clk); #1 beat_tick = 1'b0;
  endtask

  task automatic restart_capture();
    @(posedge clk); #1 capture_en = 1'b0;
    @(posedge clk); #1 capture_en = 1'b1;
  endtask

  task automatic check_pats(input string tag, input logic [15:0] e1, input logic [15:0] e2,
                            input logic [15:0] e3, input logic [15:0] e4);
    check({tag, ".qOut1"}, 32'(qOut1), 32'(e1));
    check({tag, ".qOut2"}, 32'(qOut2), 32'(e2));
    check({tag, ".qOut3"}, 32'(qOut3), 32'(e3));
    check({tag, ".qOut4"}, 32'(qOut4), 32'(e4));
  endtask

  typedef struct {
    int          period;
    logic [3:0]  note;
    logic [16:0] pout;
  } vec_t;

  vec_t tbl[13];

  initial begin : main
    int fd0, p, prev_p, r;
    logic [3:0]  bits;
    logic [15:0] exp_pat[4];

    tbl[0]  = '{284, 4'b0001, 17'd284};
    tbl[1]  = '{239, 4'b0010, 17'd239};
    tbl[2]  = '{218, 4'b0100, 17'd218};
    tbl[3]  = '{179, 4'b1000, 17'd179};
    tbl[4]  = '{184, 4'b1000, 17'd184};
    tbl[5]  = '{185, 4'b0000, 17'd185};
    tbl[6]  = '{174, 4'b1000, 17'd174};
    tbl[7]  = '{173, 4'b0000, 17'd173};
    tbl[8]  = '{279, 4'b0001, 17'd279};
    tbl[9]  = '{290, 4'b0000, 17'd290};
    tbl[10] = '{223, 4'b0100, 17'd223};
    tbl[11] = '{501, 4'b0000, 17'd500};
    tbl[12] = '{600, 4'b0000, 17'd500};

    // reset state
    cycles(3);
    check_pats("reset", 16'h0, 16'h0, 16'h0, 16'h0);
    check("reset.step", 32'(step), 32'd0);
    check("reset.note_now", 32'(note_now), 32'd0);
    check("reset.period_out", 32'(period_out), 32'd0);
    check("reset.frame_done", 32'(frame_done), 32'd0);
    @(posedge clk); #1 resetN = 1'b1;
    cycles(2);
    check("post_reset.step", 32'(step), 32'd0);
    check("post_reset.period_out", 32'(period_out), 32'd0);

    // classification table including window edges and timeout saturation
    for (int i = 0; i < 13; i++) begin
      next_period = tbl[i].period;
      cycles(1200);
      check($sformatf("tbl%0d.note_now", i), 32'(note_now), 32'(tbl[i].note));
      check($sformatf("tbl%0d.period_out", i), 32'(period_out), 32'(tbl[i].pout));
    end

    // steady A for a full frame
    next_period = TA;
    cycles(1200);
    @(posedge clk); #1 capture_en = 1'b1;
    fd0 = fd_cnt;
    for (int s = 0; s < 16; s++) begin
      cycles(30);
      tick();
    end
    cycles(3);
    check_pats("a_frame", 16'hFFFF, 16'h0, 16'h0, 16'h0);
    check("a_frame.frame_done_count", 32'(fd_cnt - fd0), 32'd1);
    check("a_frame.step", 32'(step), 32'd0);

    // C on steps 0..7, silence from step 8
    next_period = TC;
    cycles(1200);
    restart_capture();
    fd0 = fd_cnt;
    for (int s = 0; s < 7; s++) begin
      cycles(30);
      tick();
    end
    next_period = 0;
    cycles(1200);
    check("silence.note_now", 32'(note_now), 32'd0);
    check("silence.period_out", 32'(period_out), 32'(TTO));
    for (int s = 7; s < 16; s++) begin
      cycles(30);
      tick();
    end
    cycles(3);
    check_pats("c_half", 16'h0, 16'h00FF, 16'h0, 16'h0);
    check("c_half.frame_done_count", 32'(fd_cnt - fd0), 32'd1);

    // D and F alternating inside one step
    restart_capture();
    next_period = TD;
    alt_period  = TF;
    cycles(1500);
    tick();
    cycles(2);
    check_pats("df_step", 16'h0, 16'h0, 16'h0001, 16'h0001);
    check("df_step.step", 32'(step), 32'd1);
    alt_period = 0;

    // leave REC (patterns hold), then re-enter with a beat_tick in the same cycle
    @(posedge clk); #1 capture_en = 1'b0;
    cycles(1);
    check("idle_hold.qOut3", 32'(qOut3), 32'h0001);
    check("idle_hold.step", 32'(step), 32'd0);
    capture_en = 1'b1;
    beat_tick  = 1'b1;
    @(posedge clk); #1 beat_tick = 1'b0;
    check_pats("reenter", 16'h0, 16'h0, 16'h0, 16'h0);
    check("reenter.step", 32'(step), 32'd0);
    cycles(2);
    check("reenter_later.step", 32'(step), 32'd0);

    // randomized frames against the step-level model
    r = $urandom_range(0, 3);
    prev_p = center(r);
    next_period = prev_p;
    cycles(1200);
    restart_capture();
    for (int f = 0; f < 2; f++) begin
      fd0 = fd_cnt;
      for (int s = 0; s < 16; s++) begin
        r = $urandom_range(0, 4);
        if (r < 4) p = center(r) + int'($urandom_range(0, 2 * TTOL)) - TTOL;
        else p = int'($urandom_range(300, 360));
        next_period = p;
        cycles(STEP_LEN - 2);
        check($sformatf("rnd%0d_%0d.note_now", f, s), 32'(note_now), 32'(ref_note(p)));
        check($sformatf("rnd%0d_%0d.period_out", f, s), 32'(period_out), 32'(p));
        // the previous step's note is still live until the new tone is first classified
        bits = ref_note(p) | ref_note(prev_p);
        for (int k = 0; k < 4; k++) exp_pat[k][s] = bits[k];
        tick();
        prev_p = p;
      end
      cycles(3);
      check_pats($sformatf("rnd%0d", f), exp_pat[0], exp_pat[1], exp_pat[2], exp_pat[3]);
      check($sformatf("rnd%0d.frame_done_count", f), 32'(fd_cnt - fd0), 32'd1);
    end

    // asynchronous reset in the middle of recording
    next_period = TA;
    cycles(1200);
    restart_capture();
    for (int s = 0; s < 9; s++) begin
      cycles(30);
      tick();
    end
    check("pre_reset.step", 32'(step), 32'd9);
    #2 resetN = 1'b0;
    #1;
    check_pats("async_reset", 16'h0, 16'h0, 16'h0, 16'h0);
    check("async_reset.step", 32'(step), 32'd0);
    check("async_reset.note_now", 32'(note_now), 32'd0);
    check("async_reset.period_out", 32'(period_out), 32'd0);
    check("async_reset.frame_done", 32'(frame_done), 32'd0);
    cycles(3);
    @(posedge clk); #1 resetN = 1'b1;
    cycles(1000);
    tick();
    cycles(2);
    check("after_reset_idle.step", 32'(step), 32'd0);
    check("after_reset_idle.qOut1", 32'(qOut1), 32'd0);
    restart_capture();
    cycles(30);
    tick();
    cycles(2);
    check("after_reset_rec.qOut1", 32'(qOut1), 32'h0001);
    check("after_reset_rec.step", 32'(step), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
